// File: rtl/ens_vote_pkg.sv
// Shared types for the ensemble vote stage: default sizes, width helpers,
// the per-class vote-count array and the argmax result bundle.
package ens_vote_pkg;

    localparam int NUM_CLASSES_D = 10;
    localparam int ENS_D         = 4;

    function automatic int cnt_w(input int ens);
        return $clog2(ens + 1);
    endfunction

    function automatic int idx_w(input int nc);
        return (nc > 1) ? $clog2(nc) : 1;
    endfunction

    localparam int CNT_W_D = cnt_w(ENS_D);
    localparam int IDX_W_D = idx_w(NUM_CLASSES_D);

    typedef logic [NUM_CLASSES_D-1:0][CNT_W_D-1:0] cnt_arr_t;

    typedef struct packed {
        logic [IDX_W_D-1:0] cls;
        logic [CNT_W_D-1:0] count;
        logic               novote;
        logic               tie;
    } result_t;

endpackage

// File: rtl/ens_argmax_tree.sv
// Combinational argmax over per-class vote counts; ties go to the lowest
// class index, and all-zero counts report novote.
module ens_argmax_tree
    import ens_vote_pkg::*;
(
    input  cnt_arr_t counts,
    output result_t  res
);

    logic [IDX_W_D-1:0] best;
    logic [CNT_W_D-1:0] top_cnt;
    logic               dup;

    always_comb begin
        best    = '0;
        top_cnt = counts[0];
        dup     = 1'b0;
        // strict > keeps the earliest class on equal counts
        for (int c = 1; c < NUM_CLASSES_D; c++) begin
            if (counts[c] > top_cnt) begin
                top_cnt = counts[c];
                best    = IDX_W_D'(c);
                dup     = 1'b0;
            end else if (counts[c] == top_cnt) begin
                dup = 1'b1;
            end
        end
        res.cls    = best;
        res.count  = top_cnt;
        res.novote = (top_cnt == '0);
        res.tie    = dup && (top_cnt != '0);
    end

endmodule

// File: rtl/ens_vote_argmax.sv
// Two-stage ensemble vote: S1 popcounts per class, S2 argmax result.
// Optional statistics counters are enabled with ENS_VOTE_STATS_EN.
module ens_vote_argmax
    import ens_vote_pkg::*;
#(
    parameter  int NUM_CLASSES = NUM_CLASSES_D,
    parameter  int ENS         = ENS_D,
    parameter  int STAT_W      = 32,
    localparam int CNT_W       = cnt_w(ENS),
    localparam int IDX_W       = idx_w(NUM_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CLASSES*ENS-1:0] in_votes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_class,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_novote,
    output logic                     out_tie
`ifdef ENS_VOTE_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [STAT_W-1:0]        stat_samples,
    output logic [STAT_W-1:0]        stat_ties
`endif
);

    logic     adv;
    logic     s1_valid;
    logic     s2_valid;
    cnt_arr_t pop;
    cnt_arr_t s1_cnt;
    result_t  res;
    result_t  s2_res;

    // one global advance: every stage moves or every stage holds
    assign adv      = !s2_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int e = 0; e < ENS; e++) begin
                pop[c] = pop[c] + CNT_W'(in_votes[e*NUM_CLASSES+c]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_cnt <= pop;
        end
    end

    ens_argmax_tree u_argmax (
        .counts (s1_cnt),
        .res    (res)
    );

    // S2 data is reset so the ports read zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_res <= '0;
        end else if (adv) begin
            s2_res <= res;
        end
    end

    assign out_valid  = s2_valid;
    assign out_class  = s2_res.cls;
    assign out_count  = s2_res.count;
    assign out_novote = s2_res.novote;
    assign out_tie    = s2_res.tie;

`ifdef ENS_VOTE_STATS_EN
    logic out_hs;

    assign out_hs = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_samples <= '0;
            stat_ties    <= '0;
        end else if (stat_clr) begin
            stat_samples <= '0;
            stat_ties    <= '0;
        end else if (out_hs) begin
            if (!(&stat_samples)) begin
                stat_samples <= stat_samples + 1'b1;
            end
            if (s2_res.tie && !(&stat_ties)) begin
                stat_ties <= stat_ties + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed self-checking bench for ens_vote_argmax (default build).
// Each scenario task drives its own stimulus and checks results inline.
module tb_ens_vote_argmax;

    localparam int NC = 10;
    localparam int EN = 4;
    localparam int W  = NC * EN;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_votes;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_class;
    logic [2:0]   out_count;
    logic         out_novote;
    logic         out_tie;

    int checks;
    int errors;

    ens_vote_argmax dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_votes   (in_votes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_count  (out_count),
        .out_novote (out_novote),
        .out_tie    (out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // votes for class cls from members 0..n-1
    function automatic logic [W-1:0] mk(input int cls, input int n);
        logic [W-1:0] v;
        v = '0;
        for (int e = 0; e < n; e++) v[e*NC+cls] = 1'b1;
        return v;
    endfunction

    // one beat with out_ready high; v1/v2 = out_valid after edge 1/2
    task automatic send_one(input logic [W-1:0] v,
                            output logic v1, output logic v2);
        @(negedge clk);
        in_valid  = 1'b1;
        in_votes  = v;
        out_ready = 1'b1;
        @(posedge clk);
        #1 v1 = out_valid;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 v2 = out_valid;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_votes  = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        checks++;
        if ({out_class, out_count, out_novote, out_tie} !== 9'd0) begin
            errors++;
            $display("FAIL reset_data got cls %0d cnt %0d nv %0b tie %0b want 0",
                     out_class, out_count, out_novote, out_tie);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bit_order;
        logic v1, v2;
        send_one(mk(3, 2), v1, v2);
        checks++;
        if (v1 !== 1'b0 || v2 !== 1'b1) begin
            errors++;
            $display("FAIL bit_order_latency got v1 %0b v2 %0b want 0 1", v1, v2);
        end
        checks++;
        if (out_class !== 4'd3 || out_count !== 3'd2
            || out_tie !== 1'b0 || out_novote !== 1'b0) begin
            errors++;
            $display("FAIL bit_order got cls %0d cnt %0d tie %0b nv %0b want 3 2 0 0",
                     out_class, out_count, out_tie, out_novote);
        end
    endtask

    task automatic test_tie;
        logic v1, v2;
        send_one(mk(2, 3) | mk(7, 3) | mk(5, 2), v1, v2);
        checks++;
        if (v2 !== 1'b1 || out_class !== 4'd2 || out_count !== 3'd3
            || out_tie !== 1'b1 || out_novote !== 1'b0) begin
            errors++;
            $display("FAIL tie got v %0b cls %0d cnt %0d tie %0b nv %0b want 1 2 3 1 0",
                     v2, out_class, out_count, out_tie, out_novote);
        end
        send_one(mk(1, 3) | mk(9, 4) | mk(4, 3), v1, v2);
        checks++;
        if (v2 !== 1'b1 || out_class !== 4'd9 || out_count !== 3'd4
            || out_tie !== 1'b0) begin
            errors++;
            $display("FAIL late_max got v %0b cls %0d cnt %0d tie %0b want 1 9 4 0",
                     v2, out_class, out_count, out_tie);
        end
    endtask

    task automatic test_extremes;
        logic v1, v2;
        send_one('0, v1, v2);
        checks++;
        if (v2 !== 1'b1 || out_novote !== 1'b1 || out_class !== 4'd0
            || out_count !== 3'd0 || out_tie !== 1'b0) begin
            errors++;
            $display("FAIL all_zero got v %0b nv %0b cls %0d cnt %0d tie %0b want 1 1 0 0 0",
                     v2, out_novote, out_class, out_count, out_tie);
        end
        send_one('1, v1, v2);
        checks++;
        if (v2 !== 1'b1 || out_class !== 4'd0 || out_count !== 3'd4
            || out_tie !== 1'b1 || out_novote !== 1'b0) begin
            errors++;
            $display("FAIL all_ones got v %0b cls %0d cnt %0d tie %0b nv %0b want 1 0 4 1 0",
                     v2, out_class, out_count, out_tie, out_novote);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got out_valid %0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        int tx, rx, cyc;
        logic stalled_seen;
        logic held;
        logic [7:0] held_val;
        logic [7:0] now_val;
        tx = 0;
        rx = 0;
        cyc = 0;
        stalled_seen = 1'b0;
        held = 1'b0;
        held_val = '0;
        while (rx < 5 && cyc < 40) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (tx < 5);
            in_votes  = (tx < 5) ? mk(tx + 1, (tx % 4) + 1) : '0;
            #1;
            now_val = {out_class, out_count, out_tie};
            if (held) begin
                checks++;
                if (!out_valid || now_val !== held_val) begin
                    errors++;
                    $display("FAIL stall_stable got v %0b %h want 1 %h",
                             out_valid, now_val, held_val);
                end
            end
            if (!in_ready) stalled_seen = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_class !== 4'(rx + 1) || out_count !== 3'((rx % 4) + 1)) begin
                    errors++;
                    $display("FAIL bp_result_%0d got cls %0d cnt %0d want %0d %0d",
                             rx, out_class, out_count, rx + 1, (rx % 4) + 1);
                end
                rx++;
            end
            held     = out_valid && !out_ready;
            held_val = now_val;
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx !== 5) begin
            errors++;
            $display("FAIL bp_count got %0d results want 5", rx);
        end
        checks++;
        if (stalled_seen !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready got never-low want dropped");
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup got out_valid %0b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_votes  = mk(6, 4);
        @(negedge clk);
        in_votes  = mk(8, 4);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_prefill got out_valid %0b want 1", out_valid);
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_immediate got v %0b rdy %0b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ar_stale got out_valid %0b want 0", out_valid);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_votes  = mk(4, 3);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_lat1 got out_valid %0b want 0", out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_class !== 4'd4 || out_count !== 3'd3) begin
            errors++;
            $display("FAIL ar_first_beat got v %0b cls %0d cnt %0d want 1 4 3",
                     out_valid, out_class, out_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bit_order();
        test_tie();
        test_extremes();
        test_backpressure();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
